regfile_wb_arbiter: RTL
=======================

Name: regfile_wb_arbiter

Overview:
- Write-back controller for the core's single-write-port register file.
- Shares the one write port between two producers, the ALU retire path and the load/store unit load return, using round-robin arbitration with valid/ready handshakes.
- Keeps a per-register pending scoreboard, set at issue and cleared at write-back grant, so the issue stage can stall on RAW and WAW hazards.
- Sits between the execute/memory stages and the register file write interface.

Parameters:
- NUM_REGS, 32, number of architectural registers (16 for RV32E); addresses >= NUM_REGS are ignored.
- DATA_WIDTH, 32, write-back data width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset_n  in  1  synchronous active-low reset.
- alu_valid  in  1  ALU write-back request.
- alu_ready  out  1  ALU request granted this cycle.
- alu_rd  in  5  ALU destination register.
- alu_data  in  DATA_WIDTH  ALU result.
- lsu_valid  in  1  load-return write-back request.
- lsu_ready  out  1  LSU request granted this cycle.
- lsu_rd  in  5  LSU destination register.
- lsu_data  in  DATA_WIDTH  load data.
- issue_valid  in  1  issue stage allocating a destination.
- issue_rd  in  5  destination being allocated.
- issue_ready  out  1  allocation accepted (no WAW conflict).
- chk_rs1  in  5  source 1 to hazard-check.
- chk_rs2  in  5  source 2 to hazard-check.
- rs1_busy  out  1  chk_rs1 has an outstanding write.
- rs2_busy  out  1  chk_rs2 has an outstanding write.
- wb_reg_write  out  1  register file write enable.
- wb_rd_addr  out  5  register file write address.
- wb_rd_data  out  DATA_WIDTH  register file write data.
- pending_mask  out  NUM_REGS  debug view of the scoreboard; bit 0 is always 0.

Behaviour:
- Reset (reset_n low at a rising edge):
  - wb_reg_write, wb_rd_addr, wb_rd_data and pending_mask are cleared to 0.
  - The round-robin pointer is set so the ALU wins the first contention.
  - In-flight requests are dropped.
  - Ready outputs are held 0 while reset_n is low.
- Arbitration (combinational, same cycle):
  - Only one valid requester: that requester is granted.
  - Both valid: the requester not granted most recently wins.
  - The pointer updates on every grant, contended or not.
  - The loser holds valid, rd and data stable until it is granted.
  - ready may depend on valid; requesters must not make valid depend on ready.
- Write-back latency: a request granted in cycle N drives the wb_* outputs in cycle N+1 (registered).
  - wb_reg_write=1 only if the granted rd != 0 and rd < NUM_REGS.
  - Grants to x0 or to an out-of-range rd are consumed, with wb_reg_write=0.
  - In a cycle with no grant, wb_reg_write=0 and wb_rd_addr/wb_rd_data hold their last values.
- Scoreboard:
  - Set: pending[rd] is set at the edge of an issue handshake (issue_valid && issue_ready) when rd != 0 and rd < NUM_REGS.
  - Clear: pending[rd] is cleared at the grant edge, so in cycle N+1 busy=0 and the register file forwards wb_rd_data.
  - Same-cycle set and clear of the same rd: set wins, since a new producer now owns the register.
  - issue_ready = !pending[issue_rd]; it is 1 for x0 and out-of-range addresses. The same-cycle clear is not bypassed.
  - rsX_busy = pending[chk_rsX], computed combinationally from registered state; it is 0 for x0 and out-of-range addresses.
- A write-back to a non-pending register is still written. It does not set or alter pending.
- ALU and LSU granted to the same rd on consecutive cycles: writes land in grant order.

Test Plan:
- Reset, then alu_valid=1, rd=5, data=0x11 in cycle 1 -> alu_ready=1 in cycle 1; wb_reg_write=1, wb_rd_addr=5, wb_rd_data=0x11 in cycle 2; then wb_reg_write=0.
- ALU (rd=3, 0xA) and LSU (rd=4, 0xB) held valid from cycle 1 -> grants ALU, LSU, ALU, LSU alternating; wb shows (3,0xA) in cycle 2 and (4,0xB) in cycle 3; each requester waits at most 1 cycle.
- Issue rd=7, then chk_rs1=7 -> rs1_busy=1 and issue of rd=7 again gives issue_ready=0; LSU write rd=7 granted in cycle N -> rs1_busy=0 and issue_ready=1 in cycle N+1.
- Issue rd=9 in the same cycle the ALU write-back for rd=9 is granted -> pending_mask[9]=1 afterwards; the write still commits.
- alu_rd=0, and rd=20 with NUM_REGS=16 -> alu_ready=1, wb_reg_write stays 0, pending_mask unchanged; issue_rd=0 -> issue_ready=1, no bit set.
- reset_n low for 1 cycle while pending_mask=0x0000_0880 and LSU valid -> pending_mask=0, wb_reg_write=0, lsu_ready=0 during reset; next grant goes to the ALU under contention.

Source files
------------

// File: rtl/regfile_wb_arbiter_if.sv
// Bundle between the write-back producers / issue stage and the write-back arbiter.
// The slave side is the arbiter; the master side is the pipeline driving requests.
interface regfile_wb_arbiter_if #(
    parameter int unsigned NUM_REGS   = 32,
    parameter int unsigned DATA_WIDTH = 32
);
    localparam int unsigned AW = 5;

    logic                  alu_valid;
    logic                  alu_ready;
    logic [AW-1:0]         alu_rd;
    logic [DATA_WIDTH-1:0] alu_data;

    logic                  lsu_valid;
    logic                  lsu_ready;
    logic [AW-1:0]         lsu_rd;
    logic [DATA_WIDTH-1:0] lsu_data;

    logic                  issue_valid;
    logic [AW-1:0]         issue_rd;
    logic                  issue_ready;

    logic [AW-1:0]         chk_rs1;
    logic [AW-1:0]         chk_rs2;
    logic                  rs1_busy;
    logic                  rs2_busy;

    logic                  wb_reg_write;
    logic [AW-1:0]         wb_rd_addr;
    logic [DATA_WIDTH-1:0] wb_rd_data;
    logic [NUM_REGS-1:0]   pending_mask;

    modport master (
        output alu_valid, alu_rd, alu_data,
        output lsu_valid, lsu_rd, lsu_data,
        output issue_valid, issue_rd, chk_rs1, chk_rs2,
        input  alu_ready, lsu_ready, issue_ready, rs1_busy, rs2_busy,
        input  wb_reg_write, wb_rd_addr, wb_rd_data, pending_mask
    );

    modport slave (
        input  alu_valid, alu_rd, alu_data,
        input  lsu_valid, lsu_rd, lsu_data,
        input  issue_valid, issue_rd, chk_rs1, chk_rs2,
        output alu_ready, lsu_ready, issue_ready, rs1_busy, rs2_busy,
        output wb_reg_write, wb_rd_addr, wb_rd_data, pending_mask
    );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter for the single register-file write port (ALU vs LSU),
// plus the per-register pending scoreboard used by issue for RAW/WAW stalls.
module regfile_wb_arbiter #(
    parameter int unsigned NUM_REGS   = 32,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset_n,
    regfile_wb_arbiter_if.slave  bus
);
    localparam int unsigned AW  = 5;
    localparam int unsigned SBW = 32;

    typedef enum logic {
        PRI_ALU = 1'b0,
        PRI_LSU = 1'b1
    } rr_e;

    rr_e                   rr_q, rr_d;
    logic [NUM_REGS-1:0]   pend_q, pend_d;
    logic                  wb_we_q, wb_we_d;
    logic [AW-1:0]         wb_addr_q, wb_addr_d;
    logic [DATA_WIDTH-1:0] wb_data_q, wb_data_d;

    logic [SBW-1:0]        pend_ext;
    logic                  alu_gnt, lsu_gnt, any_gnt, issue_rdy, issue_fire;
    logic [AW-1:0]         gnt_rd;
    logic [DATA_WIDTH-1:0] gnt_data;
    logic [SBW-1:0]        set_mask, clr_mask, pend_nxt_ext;

    // Widened view so any 5-bit address indexes safely; out-of-range bits read as 0.
    assign pend_ext = SBW'(pend_q);

    // Grant, scoreboard and write-back next-state logic.
    always_comb begin
        rr_d         = rr_q;
        wb_we_d      = 1'b0;
        wb_addr_d    = wb_addr_q;
        wb_data_d    = wb_data_q;
        gnt_rd       = '0;
        gnt_data     = '0;
        set_mask     = '0;
        clr_mask     = '0;

        alu_gnt    = reset_n && bus.alu_valid && (!bus.lsu_valid || rr_q == PRI_ALU);
        lsu_gnt    = reset_n && bus.lsu_valid && !alu_gnt;
        any_gnt    = alu_gnt || lsu_gnt;
        issue_rdy  = reset_n && !pend_ext[bus.issue_rd];
        issue_fire = bus.issue_valid && issue_rdy;

        if (alu_gnt) begin
            gnt_rd   = bus.alu_rd;
            gnt_data = bus.alu_data;
            rr_d     = PRI_LSU;
        end else if (lsu_gnt) begin
            gnt_rd   = bus.lsu_rd;
            gnt_data = bus.lsu_data;
            rr_d     = PRI_ALU;
        end

        if (any_gnt) begin
            wb_we_d   = (gnt_rd != '0) && (SBW'(gnt_rd) < NUM_REGS);
            wb_addr_d = gnt_rd;
            wb_data_d = gnt_data;
            clr_mask  = SBW'(1) << gnt_rd;
        end

        if (issue_fire && bus.issue_rd != '0)
            set_mask = SBW'(1) << bus.issue_rd;

        // Set after clear: a freshly issued producer owns the register.
        pend_nxt_ext = (pend_ext & ~clr_mask) | set_mask;
        pend_d       = NUM_REGS'(pend_nxt_ext);
        pend_d[0]    = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rr_q      <= PRI_ALU;
            pend_q    <= '0;
            wb_we_q   <= 1'b0;
            wb_addr_q <= '0;
            wb_data_q <= '0;
        end else begin
            rr_q      <= rr_d;
            pend_q    <= pend_d;
            wb_we_q   <= wb_we_d;
            wb_addr_q <= wb_addr_d;
            wb_data_q <= wb_data_d;
        end
    end

    assign bus.alu_ready    = alu_gnt;
    assign bus.lsu_ready    = lsu_gnt;
    assign bus.issue_ready  = issue_rdy;
    assign bus.rs1_busy     = pend_ext[bus.chk_rs1];
    assign bus.rs2_busy     = pend_ext[bus.chk_rs2];
    assign bus.wb_reg_write = wb_we_q;
    assign bus.wb_rd_addr   = wb_addr_q;
    assign bus.wb_rd_data   = wb_data_q;
    assign bus.pending_mask = pend_q;
endmodule
